// File: rtl/control_unit_fsm_if.sv
// Control bundle between the instruction sequencer and the processor datapath.
// master drives the datapath controls; slave supplies Run, IR and Gnz.
interface control_unit_fsm_if #(
  parameter int IW = 10,
  parameter int NR = 8
);
  logic          Run;
  logic [IW-1:0] IR;
  logic          Gnz;
  logic          IRIn;
  logic [NR-1:0] Rin;
  logic [NR-1:0] Rout;
  logic          Gout;
  logic          DINout;
  logic          Ain;
  logic          Gin;
  logic          AddSub;
  logic          Done;

  modport master (
    input  Run, IR, Gnz,
    output IRIn, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done
  );

  modport slave (
    output Run, IR, Gnz,
    input  IRIn, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done
  );
endinterface

// File: rtl/control_unit_fsm.sv
// Instruction sequencer: walks each instruction through T0..T3 and decodes
// the datapath controls combinationally from Tstep, IR, Run and Gnz.
module control_unit_fsm #(
  parameter int IW = 10,
  parameter int NR = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  control_unit_fsm_if.master    cu
);
  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MVNZ = 4'b0100;

  tstep_e Tstep, tstep_nxt;

  logic [3:0]    opcode;
  logic [NR-1:0] x_oh, y_oh;
  logic          irin, gout, dinout, ain, gin, addsub, done;
  logic [NR-1:0] rin, rout;

  assign opcode = cu.IR[IW-1:IW-4];
  assign x_oh   = {{(NR-1){1'b0}}, 1'b1} << cu.IR[5:3];
  assign y_oh   = {{(NR-1){1'b0}}, 1'b1} << cu.IR[2:0];

  always_ff @(posedge Clock) begin
    if (Reset) Tstep <= T0;
    else       Tstep <= tstep_nxt;
  end

  always_comb begin
    tstep_nxt = Tstep;
    irin      = 1'b0;
    rin       = '0;
    rout      = '0;
    gout      = 1'b0;
    dinout    = 1'b0;
    ain       = 1'b0;
    gin       = 1'b0;
    addsub    = 1'b0;
    done      = 1'b0;
    // Reset silences every control so an aborted instruction writes nothing.
    if (Reset) begin
      tstep_nxt = T0;
    end else begin
      unique case (Tstep)
        T0: begin
          irin = cu.Run;
          if (cu.Run) tstep_nxt = T1;
        end
        T1: begin
          tstep_nxt = T0;
          case (opcode)
            OP_MV: begin
              rout = y_oh;
              rin  = x_oh;
              done = 1'b1;
            end
            OP_MVI: begin
              dinout = 1'b1;
              rin    = x_oh;
              done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              rout      = x_oh;
              ain       = 1'b1;
              tstep_nxt = T2;
            end
            OP_MVNZ: begin
              done = 1'b1;
              if (cu.Gnz) begin
                rout = y_oh;
                rin  = x_oh;
              end
            end
            default: done = 1'b1;
          endcase
        end
        T2: begin
          rout      = y_oh;
          gin       = 1'b1;
          addsub    = (opcode == OP_SUB);
          tstep_nxt = T3;
        end
        T3: begin
          gout      = 1'b1;
          rin       = x_oh;
          done      = 1'b1;
          tstep_nxt = T0;
        end
        default: tstep_nxt = T0;
      endcase
    end
  end

  assign cu.IRIn   = irin;
  assign cu.Rin    = rin;
  assign cu.Rout   = rout;
  assign cu.Gout   = gout;
  assign cu.DINout = dinout;
  assign cu.Ain    = ain;
  assign cu.Gin    = gin;
  assign cu.AddSub = addsub;
  assign cu.Done   = done;
endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench: each driven cycle pushes its expected control vector,
// the negedge monitor pops and compares against the DUT.
module tb_control_unit_fsm;
  localparam int IW = 10;
  localparam int NR = 8;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  control_unit_fsm_if #(.IW(IW), .NR(NR)) cu ();

  control_unit_fsm #(.IW(IW), .NR(NR)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .cu    (cu.master)
  );

  typedef struct {
    string       tag;
    logic [22:0] vec;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [22:0] obs;
  assign obs = {cu.IRIn, cu.Rin, cu.Rout, cu.Gout, cu.DINout, cu.Ain, cu.Gin, cu.AddSub, cu.Done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [22:0] mk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                     input logic gout, input logic din, input logic ain,
                                     input logic gin, input logic as, input logic done);
    return {irin, rin, rout, gout, din, ain, gin, as, done};
  endfunction

  // One clock cycle: drive inputs just after the edge, queue what this cycle must show.
  task automatic cyc(input string tag, input logic rst, input logic run, input logic [IW-1:0] ir,
                     input logic gnz, input logic [22:0] e);
    exp_t x;
    @(posedge Clock);
    #1;
    Reset  = rst;
    cu.Run = run;
    cu.IR  = ir;
    cu.Gnz = gnz;
    x.tag = tag;
    x.vec = e;
    q.push_back(x);
  endtask

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk(x.tag, {9'd0, obs}, {9'd0, x.vec});
    end
    if (Reset !== 1'bx) begin
      chk("bus_excl", $countones({cu.Rout, cu.Gout, cu.DINout}) <= 1, 1);
      chk("onehot", $onehot0(cu.Rin) && $onehot0(cu.Rout), 1);
    end
  end

  localparam logic [22:0] Z = 23'd0;

  initial begin
    logic [IW-1:0] add12, sub12, mvi5, mvnz07, op15, mv33, add22, mv12;
    add12  = 10'b0010_001_010;
    sub12  = 10'b0011_001_010;
    mvi5   = 10'b0001_101_000;
    mvnz07 = 10'b0100_000_111;
    op15   = 10'b1111_011_100;
    mv33   = 10'b0000_011_011;
    add22  = 10'b0010_010_010;
    mv12   = 10'b0000_001_010;

    Reset = 1'b1; cu.Run = 1'b1; cu.IR = add12; cu.Gnz = 1'b0;

    for (int i = 0; i < 3; i++) cyc("reset", 1, 1, add12, 0, Z);

    cyc("add_t0", 0, 1, add12, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("add_t1", 0, 0, add12, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
    cyc("add_t2", 0, 0, add12, 0, mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0));
    cyc("add_t3", 0, 0, add12, 0, mk(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1));
    cyc("idle",   0, 0, add12, 0, Z);

    cyc("mvi_t0", 0, 1, mvi5, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("mvi_t1", 0, 0, mvi5, 0, mk(0, 8'h20, 8'h00, 0, 1, 0, 0, 0, 1));
    cyc("mvi_nx", 0, 0, mvi5, 0, Z);

    cyc("sub_t0", 0, 1, sub12, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("sub_t1", 0, 0, sub12, 1, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
    cyc("sub_t2", 0, 0, sub12, 0, mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 1, 0));
    cyc("sub_t3", 0, 0, sub12, 0, mk(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1));

    cyc("mvnz0_t0", 0, 1, mvnz07, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("mvnz0_t1", 0, 0, mvnz07, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
    cyc("mvnz1_t0", 0, 1, mvnz07, 1, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("mvnz1_t1", 0, 0, mvnz07, 1, mk(0, 8'h01, 8'h80, 0, 0, 0, 0, 0, 1));

    // Abort a sub in T2; the following cycle must already be T0.
    cyc("abort_t0", 0, 1, sub12, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("abort_t1", 0, 0, sub12, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
    cyc("abort_rst", 1, 0, sub12, 0, Z);
    cyc("op15_t0", 0, 1, op15, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("op15_t1", 0, 0, op15, 1, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));

    cyc("mv33_t0", 0, 1, mv33, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("mv33_t1", 0, 0, mv33, 0, mk(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1));
    cyc("add22_t0", 0, 1, add22, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("add22_t1", 0, 0, add22, 0, mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0));
    cyc("add22_t2", 0, 0, add22, 0, mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0));
    cyc("add22_t3", 0, 0, add22, 0, mk(0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1));

    // Run held high: mv, add, mvi back to back, Done on cycles 2, 6, 8.
    cyc("b2b_c1", 0, 1, mv12,  0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("b2b_c2", 0, 1, mv12,  0, mk(0, 8'h02, 8'h04, 0, 0, 0, 0, 0, 1));
    cyc("b2b_c3", 0, 1, add12, 0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("b2b_c4", 0, 1, add12, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
    cyc("b2b_c5", 0, 1, add12, 0, mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 0, 0));
    cyc("b2b_c6", 0, 1, add12, 0, mk(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1));
    cyc("b2b_c7", 0, 1, mvi5,  0, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    cyc("b2b_c8", 0, 1, mvi5,  0, mk(0, 8'h20, 8'h00, 0, 1, 0, 0, 0, 1));
    cyc("b2b_c9", 0, 0, mvi5,  0, Z);

    repeat (2) @(posedge Clock);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
